alu_pwr_seq: RTL and testbench

ALU_PWR_SEQ -- requirements
Module: alu_pwr_seq

---
 rtl/alu_pwr_seq.sv | 173 +++++++++++++++++
 tb/tb_alu_pwr_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_pwr_seq
// Description : Power/isolation sequencer for a switchable ALU domain.
//               It drives a Moore FSM (OFF/PWRUP/ON/DRAIN/ISO) with registered
//               power, isolation and status outputs. It also gates the ALU
//               start pin while the domain is not fully on.
// Revision    : 1.0  initial release
// ============================================================================
module alu_pwr_seq #(
  parameter int ISO_DLY   = 2,
  parameter int PWR_DLY   = 4,
  parameter int DRAIN_MAX = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sleep_req,
  input  logic       wake_req,
  input  logic       start_in,
  input  logic       alu_busy,
  output logic       start_out,
  output logic       alu_pwr_en,
  output logic       iso_en,
  output logic       alu_ready,
  output logic       sleep_ack,
  output logic       sleep_err,
  output logic [2:0] state_o
);

  localparam logic [7:0] C_ISO_DLY   = 8'(ISO_DLY);
  localparam logic [7:0] C_PWR_DLY   = 8'(PWR_DLY);
  localparam logic [7:0] C_DRAIN_MAX = 8'(DRAIN_MAX);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_PWRUP = 3'd1,
    S_ON    = 3'd2,
    S_DRAIN = 3'd3,
    S_ISO   = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic [7:0] w_cnt_nxt;
  logic       w_err_nxt;

  logic       r_pwr_en;
  logic       r_iso_en;
  logic       r_ready;
  logic       r_ack;
  logic       r_err;
  logic       w_pwr_en_nxt;
  logic       w_iso_en_nxt;
  logic       w_ready_nxt;
  logic       w_ack_nxt;

  // Next-state and dwell counter: the counter is loaded on entry to each timed
  // state and the state is left when it reaches 1 (i.e. after exactly N cycles).
  // The "<= 1" comparisons also keep a zeroed counter from wrapping.
  always_comb begin
    w_state_nxt = S_OFF;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    case (r_state)
      S_OFF: begin
        if (wake_req) begin
          w_state_nxt = S_PWRUP;
          w_cnt_nxt   = C_PWR_DLY;
        end else begin
          w_state_nxt = S_OFF;
        end
      end
      S_PWRUP: begin
        if (r_cnt <= 8'd1) begin
          w_state_nxt = S_ON;
        end else begin
          w_state_nxt = S_PWRUP;
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
      S_ON: begin
        // Sleep takes priority; wake is meaningless while already on.
        if (sleep_req) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = C_DRAIN_MAX;
        end else begin
          w_state_nxt = S_ON;
        end
      end
      S_DRAIN: begin
        if (!alu_busy) begin
          w_state_nxt = S_ISO;
          w_cnt_nxt   = C_ISO_DLY;
        end else if (r_cnt <= 8'd1) begin
          w_state_nxt = S_ON;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
      S_ISO: begin
        if (r_cnt <= 8'd1) begin
          w_state_nxt = S_OFF;
        end else begin
          w_state_nxt = S_ISO;
          w_cnt_nxt   = r_cnt - 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_OFF;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Output decode of the upcoming state so the registered outputs line up with r_state.
  always_comb begin
    w_pwr_en_nxt = 1'b0;
    w_iso_en_nxt = 1'b1;
    w_ready_nxt  = 1'b0;
    w_ack_nxt    = 1'b0;
    case (w_state_nxt)
      S_OFF:   w_ack_nxt = 1'b1;
      S_PWRUP: w_pwr_en_nxt = 1'b1;
      S_ON: begin
        w_pwr_en_nxt = 1'b1;
        w_iso_en_nxt = 1'b0;
        w_ready_nxt  = 1'b1;
      end
      S_DRAIN: begin
        w_pwr_en_nxt = 1'b1;
        w_iso_en_nxt = 1'b0;
      end
      S_ISO:   w_pwr_en_nxt = 1'b1;
      default: w_ack_nxt = 1'b1;
    endcase
  end

  // State, counter and registered outputs; reset lands directly on the OFF
  // decode, so iso_en is never released on the way into reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_OFF;
      r_cnt    <= 8'd0;
      r_pwr_en <= 1'b0;
      r_iso_en <= 1'b1;
      r_ready  <= 1'b0;
      r_ack    <= 1'b1;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_pwr_en <= w_pwr_en_nxt;
      r_iso_en <= w_iso_en_nxt;
      r_ready  <= w_ready_nxt;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // No start may slip out in the cycle a sleep request is being accepted.
  assign start_out  = start_in & (r_state == S_ON) & ~sleep_req;
  assign alu_pwr_en = r_pwr_en;
  assign iso_en     = r_iso_en;
  assign alu_ready  = r_ready;
  assign sleep_ack  = r_ack;
  assign sleep_err  = r_err;
  assign state_o    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alu_pwr_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pwr_seq
// Description : Self-checking bench for alu_pwr_seq: directed scenarios plus
//               randomized traffic checked against a time-in-state model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_pwr_seq;

  localparam int ISO_DLY   = 2;
  localparam int PWR_DLY   = 4;
  localparam int DRAIN_MAX = 16;

  localparam int M_OFF = 0, M_PWRUP = 1, M_ON = 2, M_DRAIN = 3, M_ISO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sleep_req = 1'b0;
  logic       wake_req  = 1'b0;
  logic       start_in  = 1'b0;
  logic       alu_busy  = 1'b0;
  logic       start_out, alu_pwr_en, iso_en, alu_ready, sleep_ack, sleep_err;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;

  alu_pwr_seq #(.ISO_DLY(ISO_DLY), .PWR_DLY(PWR_DLY), .DRAIN_MAX(DRAIN_MAX)) dut (
    .clk(clk), .rst(rst), .sleep_req(sleep_req), .wake_req(wake_req),
    .start_in(start_in), .alu_busy(alu_busy), .start_out(start_out),
    .alu_pwr_en(alu_pwr_en), .iso_en(iso_en), .alu_ready(alu_ready),
    .sleep_ack(sleep_ack), .sleep_err(sleep_err), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Reference model: which state we are in and how many cycles we have spent there.
  int m_state = M_OFF;
  int m_el    = 0;
  bit m_err   = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= M_OFF; m_el <= 0; m_err <= 1'b0;
    end else begin
      m_err <= 1'b0;
      m_el  <= m_el + 1;
      case (m_state)
        M_OFF:   if (wake_req) begin m_state <= M_PWRUP; m_el <= 0; end
        M_PWRUP: if (m_el + 1 == PWR_DLY) begin m_state <= M_ON; m_el <= 0; end
        M_ON:    if (sleep_req) begin m_state <= M_DRAIN; m_el <= 0; end
        M_DRAIN: begin
          if (!alu_busy) begin m_state <= M_ISO; m_el <= 0; end
          else if (m_el + 1 == DRAIN_MAX) begin m_state <= M_ON; m_el <= 0; m_err <= 1'b1; end
        end
        M_ISO:   if (m_el + 1 == ISO_DLY) begin m_state <= M_OFF; m_el <= 0; end
        default: m_state <= M_OFF;
      endcase
    end
  end

  // Every-cycle comparison against the model plus the safety invariants.
  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if (state_o !== 3'(m_state)) begin n_fail++; $display("FAIL mon_state t=%0t got %0d exp %0d", $time, state_o, m_state); end
      n_tests++;
      if (alu_pwr_en !== (m_state != M_OFF)) begin n_fail++; $display("FAIL mon_pwr t=%0t got %b exp %b", $time, alu_pwr_en, m_state != M_OFF); end
      n_tests++;
      if (iso_en !== (m_state == M_OFF || m_state == M_PWRUP || m_state == M_ISO)) begin
        n_fail++; $display("FAIL mon_iso t=%0t got %b state %0d", $time, iso_en, m_state);
      end
      n_tests++;
      if (alu_ready !== (m_state == M_ON) || sleep_ack !== (m_state == M_OFF)) begin
        n_fail++; $display("FAIL mon_rdy_ack t=%0t got %b/%b state %0d", $time, alu_ready, sleep_ack, m_state);
      end
      n_tests++;
      if (sleep_err !== m_err) begin n_fail++; $display("FAIL mon_err t=%0t got %b exp %b", $time, sleep_err, m_err); end
      n_tests++;
      if (start_out !== (start_in && m_state == M_ON && !sleep_req)) begin
        n_fail++; $display("FAIL mon_start t=%0t got %b state %0d in %b sleep %b", $time, start_out, m_state, start_in, sleep_req);
      end
      n_tests++;
      if ((alu_pwr_en === 1'b0 && iso_en === 1'b0) || (start_out === 1'b1 && state_o !== 3'd2)) begin
        n_fail++; $display("FAIL invariant t=%0t pwr %b iso %b start %b state %0d", $time, alu_pwr_en, iso_en, start_out, state_o);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; sleep_req = 0; wake_req = 0; start_in = 0; alu_busy = 0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic go_on();
    do_reset();
    wake_req = 1'b1; step(); wake_req = 1'b0;
    repeat (PWR_DLY) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; wake_req = 1'b1; start_in = 1'b1;
    step();
    n_tests++;
    if ({alu_pwr_en, iso_en, sleep_ack, alu_ready, sleep_err, start_out, state_o} !== 9'b011000_000) begin
      n_fail++; $display("FAIL reset_outputs got %b exp 011000000", {alu_pwr_en, iso_en, sleep_ack, alu_ready, sleep_err, start_out, state_o});
    end
    wake_req = 1'b0; start_in = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    n_tests++;
    if (state_o !== 3'd0 || sleep_ack !== 1'b1) begin n_fail++; $display("FAIL reset_stay_off got %0d exp 0", state_o); end
  endtask

  task automatic test_powerup();
    do_reset();
    wake_req = 1'b1; step(); wake_req = 1'b0;
    for (int i = 0; i < PWR_DLY; i++) begin
      n_tests++;
      if (state_o !== 3'd1 || alu_pwr_en !== 1'b1 || iso_en !== 1'b1) begin
        n_fail++; $display("FAIL pwrup_cycle%0d got st %0d pwr %b iso %b exp 1/1/1", i, state_o, alu_pwr_en, iso_en);
      end
      if (i < PWR_DLY - 1) step();
    end
    step();
    n_tests++;
    if (state_o !== 3'd2 || iso_en !== 1'b0 || alu_ready !== 1'b1) begin
      n_fail++; $display("FAIL pwrup_on got st %0d iso %b rdy %b exp 2/0/1", state_o, iso_en, alu_ready);
    end
    start_in = 1'b1; #1;
    n_tests++;
    if (start_out !== 1'b1) begin n_fail++; $display("FAIL start_pass got %b exp 1", start_out); end
    sleep_req = 1'b1; #1;
    n_tests++;
    if (start_out !== 1'b0) begin n_fail++; $display("FAIL start_block_sleep got %b exp 0", start_out); end
    sleep_req = 1'b0; start_in = 1'b0;
  endtask

  task automatic test_clean_down();
    go_on();
    alu_busy = 1'b0; sleep_req = 1'b1; step(); sleep_req = 1'b0;
    n_tests++;
    if (state_o !== 3'd3) begin n_fail++; $display("FAIL down_drain got %0d exp 3", state_o); end
    step();
    n_tests++;
    if (state_o !== 3'd4 || iso_en !== 1'b1 || alu_pwr_en !== 1'b1) begin n_fail++; $display("FAIL down_iso got %0d exp 4", state_o); end
    step(); step();
    n_tests++;
    if (state_o !== 3'd0 || alu_pwr_en !== 1'b0 || sleep_ack !== 1'b1) begin
      n_fail++; $display("FAIL down_off got st %0d pwr %b ack %b exp 0/0/1", state_o, alu_pwr_en, sleep_ack);
    end
  endtask

  task automatic test_drain();
    go_on();
    alu_busy = 1'b1; sleep_req = 1'b1; step(); sleep_req = 1'b0;
    for (int k = 1; k < 5; k++) begin
      start_in = k[0]; #1;
      n_tests++;
      if (state_o !== 3'd3 || start_out !== 1'b0) begin
        n_fail++; $display("FAIL drain_hold%0d got st %0d start %b exp 3/0", k, state_o, start_out);
      end
      step();
    end
    start_in = 1'b0; alu_busy = 1'b0; step();
    n_tests++;
    if (state_o !== 3'd4) begin n_fail++; $display("FAIL drain_to_iso got %0d exp 4", state_o); end
    repeat (ISO_DLY) step();
  endtask

  task automatic test_timeout();
    go_on();
    alu_busy = 1'b1; sleep_req = 1'b1; step(); sleep_req = 1'b0;
    for (int k = 1; k < DRAIN_MAX; k++) begin
      n_tests++;
      if (state_o !== 3'd3 || alu_pwr_en !== 1'b1 || iso_en !== 1'b0 || sleep_err !== 1'b0) begin
        n_fail++; $display("FAIL timeout_drain%0d got st %0d err %b exp 3/0", k, state_o, sleep_err);
      end
      step();
    end
    step();
    n_tests++;
    if (state_o !== 3'd2 || sleep_err !== 1'b1 || iso_en !== 1'b0) begin
      n_fail++; $display("FAIL timeout_on got st %0d err %b exp 2/1", state_o, sleep_err);
    end
    step();
    n_tests++;
    if (state_o !== 3'd2 || sleep_err !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse got st %0d err %b exp 2/0", state_o, sleep_err); end
  endtask

  task automatic test_back_to_back();
    go_on();
    alu_busy = 1'b1; sleep_req = 1'b1;
    repeat (DRAIN_MAX + 1) step();
    n_tests++;
    if (state_o !== 3'd2 || sleep_err !== 1'b1) begin n_fail++; $display("FAIL held_abort_on got st %0d err %b exp 2/1", state_o, sleep_err); end
    step();
    n_tests++;
    if (state_o !== 3'd3) begin n_fail++; $display("FAIL held_reenter got %0d exp 3", state_o); end
    sleep_req = 1'b0; alu_busy = 1'b0;
  endtask

  task automatic test_reset_mid_iso();
    go_on();
    sleep_req = 1'b1; step(); sleep_req = 1'b0; step();
    #2 rst = 1'b1; wake_req = 1'b1; #1;
    n_tests++;
    if (alu_pwr_en !== 1'b0 || iso_en !== 1'b1 || state_o !== 3'd0) begin
      n_fail++; $display("FAIL rst_iso got pwr %b iso %b st %0d exp 0/1/0", alu_pwr_en, iso_en, state_o);
    end
    repeat (3) step();
    n_tests++;
    if (state_o !== 3'd0) begin n_fail++; $display("FAIL rst_wake_ignored got %0d exp 0", state_o); end
    wake_req = 1'b0; rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 199) == 0) rst = 1'b1; else rst = 1'b0;
      sleep_req = ($urandom_range(0, 5) == 0);
      wake_req  = ($urandom_range(0, 3) == 0);
      alu_busy  = ($urandom_range(0, 9) < 7);
      start_in  = $urandom_range(0, 1);
      step();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    mon_en = 1'b1;
    test_powerup();
    test_clean_down();
    test_drain();
    test_timeout();
    test_back_to_back();
    test_reset_mid_iso();
    test_random();
    step();
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
